// File: rtl/vc_buffer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vc_buffer_if                                                 |
// | Description : Request/RAM/status bundle between a router input port and   |
// |               its virtual-channel buffer controller.                       |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
interface vc_buffer_if #(
    parameter int V          = 4,
    parameter int B          = 4,
    parameter int DATA_WIDTH = 32
);
    localparam int VW = $clog2(V);
    localparam int BW = $clog2(B);
    localparam int AW = VW + BW;

    logic [DATA_WIDTH-1:0] flit_in;
    logic                  flit_in_we;
    logic [V-1:0]          wr_vc;
    logic                  rd_req;
    logic [V-1:0]          rd_vc;
    logic [DATA_WIDTH-1:0] ram_rd_data;

    logic [DATA_WIDTH-1:0] ram_wr_data;
    logic [AW-1:0]         ram_wr_addr;
    logic                  ram_wr_en;
    logic [AW-1:0]         ram_rd_addr;
    logic                  ram_rd_en;
    logic [DATA_WIDTH-1:0] flit_out;
    logic                  flit_out_valid;
    logic [V-1:0]          vc_not_empty;
    logic [V-1:0]          vc_full;
    logic                  overflow_err;
    logic                  underflow_err;
    logic                  onehot_err;

    // Router side plus flit RAM read port.
    modport master (
        output flit_in, flit_in_we, wr_vc, rd_req, rd_vc, ram_rd_data,
        input  ram_wr_data, ram_wr_addr, ram_wr_en, ram_rd_addr, ram_rd_en,
        input  flit_out, flit_out_valid, vc_not_empty, vc_full,
        input  overflow_err, underflow_err, onehot_err
    );

    // Buffer controller side.
    modport slave (
        input  flit_in, flit_in_we, wr_vc, rd_req, rd_vc, ram_rd_data,
        output ram_wr_data, ram_wr_addr, ram_wr_en, ram_rd_addr, ram_rd_en,
        output flit_out, flit_out_valid, vc_not_empty, vc_full,
        output overflow_err, underflow_err, onehot_err
    );
endinterface
`default_nettype wire

// File: rtl/vc_buffer_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vc_buffer_ctrl                                               |
// | Description : Pointer/count management for V virtual-channel queues that  |
// |               share one dual-port flit RAM, with per-VC status and errors. |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module vc_buffer_ctrl #(
    parameter int V          = 4,
    parameter int B          = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    vc_buffer_if.slave bus
);
    localparam int VW = $clog2(V);
    localparam int BW = $clog2(B);
    localparam int AW = VW + BW;
    localparam logic [BW:0] C_DEPTH = (BW+1)'(B);

    function automatic logic is_onehot(input logic [V-1:0] vec);
        return (vec != '0) && ((vec & (vec - V'(1))) == '0);
    endfunction

    function automatic logic [VW-1:0] encode(input logic [V-1:0] vec);
        logic [VW-1:0] idx;
        idx = '0;
        for (int i = 0; i < V; i++) begin
            if (vec[i]) idx = VW'(i);
        end
        return idx;
    endfunction

    logic [BW-1:0] r_wr_ptr [V];
    logic [BW-1:0] r_rd_ptr [V];
    logic [BW:0]   r_count  [V];
    logic [BW:0]   w_count_nxt [V];
    logic [V-1:0]  r_not_empty;
    logic [V-1:0]  r_full;
    logic          r_flit_valid;
    logic          r_overflow;
    logic          r_underflow;
    logic          r_onehot;

    logic          w_wr_onehot;
    logic          w_rd_onehot;
    logic [VW-1:0] w_wr_idx;
    logic [VW-1:0] w_rd_idx;
    logic          w_rd_ok;
    logic          w_wr_room;
    logic          w_wr_ok;
    logic [V-1:0]  w_wr_sel;
    logic [V-1:0]  w_rd_sel;
    logic          w_overflow_evt;
    logic          w_underflow_evt;
    logic          w_onehot_evt;

    assign w_wr_onehot = is_onehot(bus.wr_vc);
    assign w_rd_onehot = is_onehot(bus.rd_vc);
    assign w_wr_idx    = encode(bus.wr_vc);
    assign w_rd_idx    = encode(bus.rd_vc);

    // Read acceptance looks only at the registered count, so a same-cycle
    // write never makes an empty VC poppable.
    assign w_rd_ok   = bus.rd_req && w_rd_onehot && (r_count[w_rd_idx] != '0);
    // A full VC still takes a write when the same VC is popped this cycle;
    // the RAM returns the old word because it reads before it writes.
    assign w_wr_room = (r_count[w_wr_idx] != C_DEPTH) ||
                       (w_rd_ok && (w_rd_idx == w_wr_idx));
    assign w_wr_ok   = bus.flit_in_we && w_wr_onehot && w_wr_room;

    assign w_wr_sel  = {V{w_wr_ok}} & bus.wr_vc;
    assign w_rd_sel  = {V{w_rd_ok}} & bus.rd_vc;

    assign w_overflow_evt  = bus.flit_in_we && w_wr_onehot && !w_wr_room;
    assign w_underflow_evt = bus.rd_req && w_rd_onehot && (r_count[w_rd_idx] == '0);
    assign w_onehot_evt    = (bus.flit_in_we && !w_wr_onehot) ||
                             (bus.rd_req && !w_rd_onehot);

    always_comb begin
        for (int v = 0; v < V; v++) begin
            w_count_nxt[v] = r_count[v];
            case ({w_wr_sel[v], w_rd_sel[v]})
                2'b10:   w_count_nxt[v] = r_count[v] + (BW+1)'(1);
                2'b01:   w_count_nxt[v] = r_count[v] - (BW+1)'(1);
                default: w_count_nxt[v] = r_count[v];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < V; v++) begin
                r_wr_ptr[v] <= '0;
                r_rd_ptr[v] <= '0;
                r_count[v]  <= '0;
            end
            r_not_empty  <= '0;
            r_full       <= '0;
            r_flit_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
            r_onehot     <= 1'b0;
        end else begin
            for (int v = 0; v < V; v++) begin
                if (w_wr_sel[v]) r_wr_ptr[v] <= r_wr_ptr[v] + BW'(1);
                if (w_rd_sel[v]) r_rd_ptr[v] <= r_rd_ptr[v] + BW'(1);
                r_count[v]     <= w_count_nxt[v];
                r_not_empty[v] <= (w_count_nxt[v] != '0);
                r_full[v]      <= (w_count_nxt[v] == C_DEPTH);
            end
            r_flit_valid <= w_rd_ok;
            if (w_overflow_evt)  r_overflow  <= 1'b1;
            if (w_underflow_evt) r_underflow <= 1'b1;
            if (w_onehot_evt)    r_onehot    <= 1'b1;
        end
    end

    // Enables are gated by reset so nothing reaches the RAM while it is held.
    assign bus.ram_wr_en      = w_wr_ok && rst_n;
    assign bus.ram_wr_addr    = {w_wr_idx, r_wr_ptr[w_wr_idx]};
    assign bus.ram_wr_data    = bus.flit_in;
    assign bus.ram_rd_en      = w_rd_ok && rst_n;
    assign bus.ram_rd_addr    = {w_rd_idx, r_rd_ptr[w_rd_idx]};

    assign bus.flit_out       = bus.ram_rd_data;
    assign bus.flit_out_valid = r_flit_valid;
    assign bus.vc_not_empty   = r_not_empty;
    assign bus.vc_full        = r_full;
    assign bus.overflow_err   = r_overflow;
    assign bus.underflow_err  = r_underflow;
    assign bus.onehot_err     = r_onehot;
endmodule
`default_nettype wire

// File: tb/tb_vc_buffer_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_vc_buffer_ctrl                                            |
// | Description : Self-checking bench for vc_buffer_ctrl against a queue model.|
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_vc_buffer_ctrl;
    localparam int V    = 4;
    localparam int B    = 4;
    localparam int DW   = 32;
    localparam int AW   = 4;
    localparam int VECW = 2*AW + 2*DW + 2*V + 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vc_buffer_if #(.V(V), .B(B), .DATA_WIDTH(DW)) bus();

    vc_buffer_ctrl #(.V(V), .B(B), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Flit RAM: registered read, read-before-write on a shared address.
    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] ram_q;
    always @(posedge clk) begin
        if (bus.ram_rd_en) ram_q <= mem[bus.ram_rd_addr];
        if (bus.ram_wr_en) mem[bus.ram_wr_addr] <= bus.ram_wr_data;
    end
    assign bus.ram_rd_data = ram_q;

    // Reference model: one FIFO per VC plus write/read totals.
    logic [DW-1:0] q [V][$];
    int            nw [V];
    int            nr [V];
    bit            m_ovf, m_udf, m_oh, m_pv;
    logic [DW-1:0] m_pd;

    int checks   = 0;
    int failures = 0;
    logic [VECW-1:0] s_obs, s_exp;
    logic            s_wen;
    logic [AW-1:0]   s_wa;

    function automatic logic [VECW-1:0] sample_obs();
        logic [AW-1:0] wa, ra;
        logic [DW-1:0] wd, fo;
        wa = bus.ram_wr_en ? bus.ram_wr_addr : '0;
        wd = bus.ram_wr_en ? bus.ram_wr_data : '0;
        ra = bus.ram_rd_en ? bus.ram_rd_addr : '0;
        fo = bus.flit_out_valid ? bus.flit_out : '0;
        return {bus.ram_wr_en, wa, wd, bus.ram_rd_en, ra, bus.flit_out_valid, fo,
                bus.vc_not_empty, bus.vc_full,
                bus.overflow_err, bus.underflow_err, bus.onehot_err};
    endfunction

    task automatic model_reset();
        for (int v = 0; v < V; v++) begin
            q[v].delete();
            nw[v] = 0;
            nr[v] = 0;
        end
        m_ovf = 0; m_udf = 0; m_oh = 0; m_pv = 0; m_pd = '0;
    endtask

    task automatic drive_idle();
        bus.flit_in_we = 1'b0; bus.wr_vc = '0; bus.flit_in = '0;
        bus.rd_req     = 1'b0; bus.rd_vc = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        drive_idle();
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // One clock cycle: drive requests, predict every output, sample, advance model.
    task automatic step(input bit we, input logic [V-1:0] wv, input logic [DW-1:0] d,
                        input bit rr, input logic [V-1:0] rv);
        int wi, ri;
        bit wv1, rv1, wok, rok;
        logic [V-1:0]  ne, fl;
        logic [AW-1:0] wa, ra;
        logic [DW-1:0] wd, fo;
        @(negedge clk);
        bus.flit_in_we = we; bus.wr_vc = wv; bus.flit_in = d;
        bus.rd_req     = rr; bus.rd_vc = rv;
        wv1 = ($countones(wv) == 1);
        rv1 = ($countones(rv) == 1);
        wi = 0; ri = 0;
        for (int i = 0; i < V; i++) begin
            if (wv[i]) wi = i;
            if (rv[i]) ri = i;
        end
        rok = rr && rv1 && (q[ri].size() > 0);
        wok = we && wv1 && ((q[wi].size() < B) || (rok && ri == wi));
        for (int i = 0; i < V; i++) begin
            ne[i] = (q[i].size() != 0);
            fl[i] = (q[i].size() == B);
        end
        wa = wok ? AW'(wi*B + nw[wi] % B) : '0;
        wd = wok ? d : '0;
        ra = rok ? AW'(ri*B + nr[ri] % B) : '0;
        fo = m_pv ? m_pd : '0;
        s_exp = {wok, wa, wd, rok, ra, m_pv, fo, ne, fl, m_ovf, m_udf, m_oh};
        #1;
        s_obs = sample_obs();
        s_wen = bus.ram_wr_en;
        s_wa  = bus.ram_wr_addr;
        @(posedge clk);
        if (we && wv1 && !wok) m_ovf = 1;
        if (rr && rv1 && !rok) m_udf = 1;
        if ((we && !wv1) || (rr && !rv1)) m_oh = 1;
        m_pv = rok;
        if (rok) begin m_pd = q[ri].pop_front(); nr[ri]++; end
        if (wok) begin q[wi].push_back(d); nw[wi]++; end
    endtask

    task automatic test_reset();
        bus.flit_in_we = 1'b1; bus.wr_vc = 4'b0001; bus.flit_in = 32'hDEAD_BEEF;
        bus.rd_req     = 1'b1; bus.rd_vc = 4'b0001;
        #1;
        checks++;
        if (sample_obs() !== '0) begin
            failures++; $display("FAIL reset_hold got=%h exp=0", sample_obs());
        end
        @(posedge clk); #1;
        checks++;
        if (sample_obs() !== '0) begin
            failures++; $display("FAIL reset_edge got=%h exp=0", sample_obs());
        end
        @(negedge clk);
        drive_idle();
        rst_n = 1'b1;
        model_reset();
        step(0, '0, '0, 0, '0);
        checks++;
        if (s_obs !== s_exp) begin
            failures++; $display("FAIL reset_idle got=%h exp=%h", s_obs, s_exp);
        end
    endtask

    task automatic test_fill_vc1();
        for (int i = 0; i < 5; i++) begin
            step(1, 4'b0010, 32'hA000_0000 + DW'(i), 0, '0);
            checks++;
            if (s_obs !== s_exp) begin
                failures++; $display("FAIL fill_vc1[%0d] got=%h exp=%h", i, s_obs, s_exp);
            end
            if (i < 4) begin
                checks++;
                if (s_wen !== 1'b1 || s_wa !== AW'(4 + i)) begin
                    failures++; $display("FAIL fill_addr[%0d] got=%0d/%0d exp=1/%0d", i, s_wen, s_wa, 4 + i);
                end
            end
            if (i == 3) begin
                #1; checks++;
                if (bus.vc_full !== 4'b0010) begin
                    failures++; $display("FAIL fill_full got=%b exp=0010", bus.vc_full);
                end
            end
        end
        #1; checks++;
        if (bus.overflow_err !== 1'b1) begin
            failures++; $display("FAIL fill_overflow got=%b exp=1", bus.overflow_err);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            step(0, '0, '0, i < 5, 4'b0010);
            checks++;
            if (s_obs !== s_exp) begin
                failures++; $display("FAIL pop_vc1[%0d] got=%h exp=%h", i, s_obs, s_exp);
            end
        end
        #1; checks++;
        if (bus.underflow_err !== 1'b1 || bus.vc_not_empty[1] !== 1'b0 || bus.flit_out_valid !== 1'b0) begin
            failures++; $display("FAIL pop_end got=%b%b%b exp=100",
                                 bus.underflow_err, bus.vc_not_empty[1], bus.flit_out_valid);
        end
    endtask

    task automatic test_wrap_vc0();
        int seq [14] = '{1,1,2,1,2,1,1,2,1,2,2,2,2,0};
        int wrap_addr [6] = '{0,1,2,3,0,1};
        int k = 0;
        apply_reset();
        foreach (seq[i]) begin
            step(seq[i] == 1, 4'b0001, $urandom, seq[i] == 2, 4'b0001);
            checks++;
            if (s_obs !== s_exp) begin
                failures++; $display("FAIL wrap_vc0[%0d] got=%h exp=%h", i, s_obs, s_exp);
            end
            if (s_wen === 1'b1 && k < 6) begin
                checks++;
                if (s_wa !== AW'(wrap_addr[k])) begin
                    failures++; $display("FAIL wrap_addr[%0d] got=%0d exp=%0d", k, s_wa, wrap_addr[k]);
                end
                k++;
            end
        end
        checks++;
        if (k != 6) begin
            failures++; $display("FAIL wrap_count got=%0d exp=6", k);
        end
    endtask

    task automatic test_full_simul();
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            // 4 fills, write X with a pop, 4 more pops, then idle.
            step(i <= 4, 4'b0100, (i == 4) ? 32'h5858_5858 : 32'hC000_0000 + DW'(i),
                 i >= 4 && i <= 8, 4'b0100);
            checks++;
            if (s_obs !== s_exp) begin
                failures++; $display("FAIL full_vc2[%0d] got=%h exp=%h", i, s_obs, s_exp);
            end
            if (i == 4) begin
                #1; checks++;
                if (bus.vc_full[2] !== 1'b1 || bus.overflow_err !== 1'b0) begin
                    failures++; $display("FAIL full_simul got=%b%b exp=10", bus.vc_full[2], bus.overflow_err);
                end
            end
        end
        step(0, '0, '0, 0, '0);
        checks++;
        if (s_obs !== s_exp || bus.flit_out !== 32'h5858_5858) begin
            failures++; $display("FAIL full_last got=%h exp=%h", bus.flit_out, 32'h5858_5858);
        end
    endtask

    task automatic test_empty_simul();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            step(i == 0, 4'b1000, 32'hD00D_0003, i < 2, 4'b1000);
            checks++;
            if (s_obs !== s_exp) begin
                failures++; $display("FAIL empty_vc3[%0d] got=%h exp=%h", i, s_obs, s_exp);
            end
            if (i == 0) begin
                #1; checks++;
                if (bus.underflow_err !== 1'b1 || bus.vc_not_empty[3] !== 1'b1) begin
                    failures++; $display("FAIL empty_simul got=%b%b exp=11", bus.underflow_err, bus.vc_not_empty[3]);
                end
            end
        end
        checks++;
        if (bus.flit_out_valid !== 1'b1 || bus.flit_out !== 32'hD00D_0003) begin
            failures++; $display("FAIL empty_pop got=%b/%h exp=1/d00d0003", bus.flit_out_valid, bus.flit_out);
        end
    endtask

    task automatic test_onehot_and_reset();
        apply_reset();
        step(0, '0, '0, 1, 4'b0110);
        checks++;
        if (s_obs !== s_exp) begin
            failures++; $display("FAIL onehot_rd got=%h exp=%h", s_obs, s_exp);
        end
        #1; checks++;
        if (bus.onehot_err !== 1'b1) begin
            failures++; $display("FAIL onehot_flag got=%b exp=1", bus.onehot_err);
        end
        step(1, 4'b0000, 32'h1, 0, '0);
        step(1, 4'b0001, 32'hE000_0001, 0, '0);
        step(1, 4'b0001, 32'hE000_0002, 0, '0);
        step(0, '0, '0, 1, 4'b0001);
        checks++;
        if (s_obs !== s_exp) begin
            failures++; $display("FAIL burst_pop got=%h exp=%h", s_obs, s_exp);
        end
        @(negedge clk);
        rst_n = 1'b0;
        bus.flit_in_we = 1'b1; bus.wr_vc = 4'b0010; bus.rd_req = 1'b1; bus.rd_vc = 4'b0001;
        #1; checks++;
        if (sample_obs() !== '0) begin
            failures++; $display("FAIL midreset_async got=%h exp=0", sample_obs());
        end
        @(posedge clk); #1; checks++;
        if (sample_obs() !== '0) begin
            failures++; $display("FAIL midreset_edge got=%h exp=0", sample_obs());
        end
        @(negedge clk);
        drive_idle();
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step(0, '0, '0, i == 0, 4'b0001);
            checks++;
            if (s_obs !== s_exp) begin
                failures++; $display("FAIL post_reset[%0d] got=%h exp=%h", i, s_obs, s_exp);
            end
        end
    endtask

    task automatic test_random();
        logic [V-1:0] wv, rv;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            wv = ($urandom_range(0, 19) == 0) ? V'($urandom) : V'(1 << $urandom_range(0, V-1));
            rv = ($urandom_range(0, 19) == 0) ? V'($urandom) : V'(1 << $urandom_range(0, V-1));
            step($urandom_range(0, 2) != 0, wv, $urandom, $urandom_range(0, 1) != 0, rv);
            checks++;
            if (s_obs !== s_exp) begin
                failures++; $display("FAIL random[%0d] got=%h exp=%h", i, s_obs, s_exp);
            end
        end
    endtask

    initial begin
        drive_idle();
        model_reset();
        test_reset();
        test_fill_vc1();
        test_back_to_back();
        test_wrap_vc0();
        test_full_simul();
        test_empty_simul();
        test_onehot_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/vc_buffer_ctrl.md
# vc_buffer_ctrl

Per-router-port input buffer controller for the VC-based mesh router: it owns the write and read pointers for V virtual-channel queues that share one dual-port flit RAM. It drives the RAM's write and read ports (address, enable, data) and returns RAM read data to the switch allocator side as a registered flit with a valid strobe. It also publishes per-VC empty/full status for credit and allocation logic.

## Interface
- V, 4: number of virtual channels; power of 2, ≥2
- B, 4: flits per VC; power of 2, ≥2
- DATA_WIDTH, 32: flit width
- VW = log2(V), BW = log2(B), AW = VW+BW: derived localparams; RAM address = {vc_index, ptr}
- clk  in  1  single clock, all logic rising-edge
- reset  in  1  asynchronous, active-low; clears all state
- flit_in  in  DATA_WIDTH  incoming flit
- flit_in_we  in  1  write request
- wr_vc  in  V  one-hot target VC for the write
- rd_req  in  1  pop request
- rd_vc  in  V  one-hot VC to pop
- ram_rd_data  in  DATA_WIDTH  RAM read data, valid one cycle after ram_rd_en
- ram_wr_data  out  DATA_WIDTH  = flit_in
- ram_wr_addr  out  AW  {enc(wr_vc), wr_ptr[enc(wr_vc)]}
- ram_wr_en  out  1  accepted write
- ram_rd_addr  out  AW  {enc(rd_vc), rd_ptr[enc(rd_vc)]}
- ram_rd_en  out  1  accepted read
- flit_out  out  DATA_WIDTH  = ram_rd_data
- flit_out_valid  out  1  flit_out holds the popped flit
- vc_not_empty  out  V  registered, count≠0 per VC
- vc_full  out  V  registered, count==B per VC
- overflow_err, underflow_err, onehot_err  out  1 each  sticky error flags

## Operation
- Per VC: wr_ptr[BW], rd_ptr[BW], count[BW+1]. Pointers wrap B-1 → 0 naturally (mod B).
- Write accepted iff flit_in_we, wr_vc one-hot, and (count<B, or same-cycle accepted read of same VC). Accepted: ram_wr_en=1, wr_ptr++.
- Read accepted iff rd_req, rd_vc one-hot, count≥1 (registered count, before this cycle's write). Accepted: ram_rd_en=1, rd_ptr++.
- count update per VC: +1 write only, −1 read only, unchanged both/neither.
- Write to full VC with no same-VC read: dropped, ram_wr_en=0, overflow_err set.
- Read of empty VC: ignored, ram_rd_en=0, underflow_err set; a same-cycle write to that VC is still accepted (data not readable until next cycle).
- flit_in_we with wr_vc zero or multi-hot, or rd_req with rd_vc zero or multi-hot: request ignored, onehot_err set.
- Simultaneous read+write on a full VC: both accepted; RAM returns the old word (read-before-write), count stays B.
- Read and write of different VCs in the same cycle are independent.
- Error flags sticky until reset.

## Timing
- Reset values: all pointers/counts 0, vc_not_empty=0, vc_full=0, flit_out_valid=0, all error flags 0. ram_wr_en/ram_rd_en combinationally 0 while reset is low. Reset asserted mid-stream discards all queued flits; no flit_out_valid follows.
- ram_wr_*, ram_rd_* are combinational from the current inputs and registered pointers/counts; no added latency.
- Write at edge t: vc_not_empty for that VC rises after edge t; earliest accepted pop at cycle t+1.
- Pop accepted in cycle t: flit_out_valid=1 for cycle t+1 only (registered ram_rd_en); flit_out = ram_rd_data in that cycle.
- Back-to-back pops: one flit per cycle, in write order per VC.
- vc_full/vc_not_empty reflect counts after the last edge; they do not see same-cycle requests.

## Test plan
- Reset, then write A0..A3 to VC1 (V=4, B=4) in consecutive cycles -> vc_full=4'b0010 after 4th edge; ram_wr_addr 4,5,6,7; 5th write dropped, overflow_err=1.
- Pop VC1 four times back-to-back -> flit_out A0,A1,A2,A3 in cycles t+1..t+4, flit_out_valid high 4 cycles; vc_not_empty[1]=0 after; 5th pop sets underflow_err, no valid.
- Write VC0 6 times interleaved with pops -> ram_wr_addr wraps 0,1,2,3,0,1; data order preserved.
- VC2 full, simultaneous write X and pop -> pop returns oldest flit (not X), count stays 4; four further pops end with X.
- Empty VC3, write and pop same cycle -> write accepted, pop ignored, underflow_err=1; pop next cycle returns flit.
- rd_vc=4'b0110 with rd_req -> no ram_rd_en, onehot_err=1; reset low mid-burst -> all outputs 0, flit_out_valid stays 0.
